alu_core: RTL

Sequential 8-bit ALU of the Jac1-8 datapath, directly upstream of the status register. It accepts one operation per start pulse and executes logic, add/sub and shift operations in one cycle, and multiply/divide iteratively in 8 cycles. On completion it presents the result and a 6-bit status vector, and pulses `stat_wr_en`. That pulse drives the status register's `wr_en`, with `sel_stat_in_alu_decoder`=1.

---
 rtl/alu_core.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_core.sv
// alu_core: sequential 8-bit ALU feeding the status register.
// Single-cycle ops (logic, add/sub, shift, compare, reserved, divide-by-zero)
// complete at the accepting edge. MUL and DIV iterate one bit per cycle for
// 8 cycles. Every completion raises done / stat_wr_en for one cycle.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start
// MUL_RUN | shift-add multiply in progress, cnt = bit being processed
// DIV_RUN | restoring divide in progress, cnt = bit being processed
// FIN     | result valid, done pulse; a new start is accepted here too
module alu_core #(
   parameter int DataWidth     = 8,
   parameter int NumStatusBits = 6
) (
   input  logic                     clk,
   input  logic                     res_n,
   input  logic                     start,
   input  logic [3:0]               opcode,
   input  logic [DataWidth-1:0]     op_a,
   input  logic [DataWidth-1:0]     op_b,
   input  logic                     carry_in,
   output logic                     busy,
   output logic                     done,
   output logic                     stat_wr_en,
   output logic [DataWidth-1:0]     result,
   output logic [DataWidth-1:0]     result_hi,
   output logic [NumStatusBits-1:0] alu_status
);

   localparam int W = DataWidth;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_CMP = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;
   localparam logic [3:0] OP_DIV = 4'd12;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2,
      FIN     = 2'd3
   } state_t;

   state_t               state;
   logic [2:0]           cnt;
   logic [2*W-1:0]       acc;
   logic [2*W-1:0]       mcand;
   logic [W-1:0]         mplier;
   logic [W-1:0]         rem;
   logic [W-1:0]         quo;
   logic [W-1:0]         b_q;
   logic                 cin_q;

   logic [W:0]           ext;
   logic [W-1:0]         sc_res;
   logic [W-1:0]         sc_hi;
   logic                 sc_c;
   logic                 sc_v;
   logic                 sc_e;
   logic                 sc_rsvd;
   logic [5:0]           sc_stat;

   logic [2*W-1:0]       mul_acc_nxt;
   logic [W:0]           div_shift;
   logic [W:0]           div_diff;
   logic                 div_ge;
   logic [W-1:0]         div_rem_nxt;
   logic [W-1:0]         div_quo_nxt;

   // Single-cycle result and flags, computed straight from the live inputs.
   always_comb begin
      ext     = '0;
      sc_res  = '0;
      sc_hi   = '0;
      sc_c    = carry_in;
      sc_v    = 1'b0;
      sc_e    = 1'b0;
      sc_rsvd = 1'b0;
      case (opcode)
         OP_ADD, OP_ADC: begin
            ext    = {1'b0, op_a} + {1'b0, op_b}
                   + {{W{1'b0}}, (opcode == OP_ADC) & carry_in};
            sc_res = ext[W-1:0];
            sc_c   = ext[W];
            sc_v   = (op_a[W-1] == op_b[W-1]) && (ext[W-1] != op_a[W-1]);
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            // Bit W of the 9-bit difference is the borrow (A < B + cin).
            ext    = {1'b0, op_a} - {1'b0, op_b}
                   - {{W{1'b0}}, (opcode == OP_SBC) & carry_in};
            sc_res = ext[W-1:0];
            sc_c   = ext[W];
            sc_v   = (op_a[W-1] != op_b[W-1]) && (ext[W-1] != op_a[W-1]);
         end
         OP_AND: sc_res = op_a & op_b;
         OP_OR:  sc_res = op_a | op_b;
         OP_XOR: sc_res = op_a ^ op_b;
         OP_NOT: sc_res = ~op_a;
         OP_SHL: {sc_c, sc_res} = {op_a, 1'b0};
         OP_SHR: {sc_res, sc_c} = {1'b0, op_a};
         OP_MUL: sc_res = '0;
         OP_DIV: begin
            // Only divide-by-zero completes in one cycle.
            sc_res = '1;
            sc_hi  = op_a;
            sc_e   = 1'b1;
         end
         default: sc_rsvd = 1'b1;
      endcase
      if (sc_rsvd) begin
         sc_stat = {1'b1, 4'b0000, carry_in};
      end else begin
         sc_stat = {sc_e, ~^sc_res, sc_v, sc_res[W-1], sc_res == '0, sc_c};
      end
   end

   // One multiply step and one restoring-divide step per cycle.
   always_comb begin
      mul_acc_nxt = acc + (mplier[0] ? mcand : '0);
      div_shift   = {rem, quo[W-1]};
      div_ge      = div_shift >= {1'b0, b_q};
      div_diff    = div_shift - {1'b0, b_q};
      div_rem_nxt = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      div_quo_nxt = {quo[W-2:0], div_ge};
   end

   assign stat_wr_en = done;

   // Sequencer with registered busy/done and result outputs.
   always_ff @(posedge clk) begin
      if (!res_n) begin
         state      <= IDLE;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         result_hi  <= '0;
         alu_status <= '0;
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         rem        <= '0;
         quo        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               if (start) begin
                  b_q   <= op_b;
                  cin_q <= carry_in;
                  cnt   <= '0;
                  if (opcode == OP_MUL) begin
                     state  <= MUL_RUN;
                     busy   <= 1'b1;
                     acc    <= '0;
                     mcand  <= {{W{1'b0}}, op_a};
                     mplier <= op_b;
                  end else if (opcode == OP_DIV && op_b != '0) begin
                     state <= DIV_RUN;
                     busy  <= 1'b1;
                     rem   <= '0;
                     quo   <= op_a;
                  end else begin
                     state      <= FIN;
                     done       <= 1'b1;
                     result     <= sc_res;
                     result_hi  <= sc_hi;
                     alu_status <= sc_stat;
                  end
               end
            end
            MUL_RUN: begin
               acc    <= mul_acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state      <= FIN;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  result     <= mul_acc_nxt[W-1:0];
                  result_hi  <= mul_acc_nxt[2*W-1:W];
                  alu_status <= {1'b0, ~^mul_acc_nxt[W-1:0], 1'b0,
                                 mul_acc_nxt[2*W-1], mul_acc_nxt == '0,
                                 |mul_acc_nxt[2*W-1:W]};
               end
            end
            DIV_RUN: begin
               rem <= div_rem_nxt;
               quo <= div_quo_nxt;
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state      <= FIN;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  result     <= div_quo_nxt;
                  result_hi  <= div_rem_nxt;
                  alu_status <= {1'b0, ~^div_quo_nxt, 1'b0, div_quo_nxt[W-1],
                                 div_quo_nxt == '0, cin_q};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
